// File: rtl/mul_32_booth_seq_pkg.sv
// ---------------------------------------------------------------------------
// mul_32_booth_seq_pkg
//    Shared definitions for the sequential radix-4 Booth multiplier:
//    FSM state encodings, Booth select codes, and the bit-pair decoder
//    that maps {Q[1],Q[0],q_m1} onto a select code.
// ---------------------------------------------------------------------------
package mul_32_booth_seq_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Term chosen for one radix-4 Booth digit
   typedef enum logic [2:0] {
      SEL_ZERO = 3'd0,
      SEL_POS1 = 3'd1,
      SEL_POS2 = 3'd2,
      SEL_NEG1 = 3'd3,
      SEL_NEG2 = 3'd4
   } booth_sel_e;

   // Booth digit for the bit pair {Q[1],Q[0]} plus the bit shifted out last
   function automatic booth_sel_e booth_select(input logic [2:0] bits);
      booth_sel_e sel;
      case (bits)
         3'b001, 3'b010: sel = SEL_POS1;
         3'b011:         sel = SEL_POS2;
         3'b100:         sel = SEL_NEG2;
         3'b101, 3'b110: sel = SEL_NEG1;
         default:        sel = SEL_ZERO;   // 000 and 111
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/mul_32_booth_seq_booth_pair_recode.sv
// ---------------------------------------------------------------------------
// mul_32_booth_seq_booth_pair_recode  (booth_pair_recode)
//    Combinational radix-4 Booth recoder. Turns one bit triple of the
//    multiplier into the signed partial-product term 0, +M, +2M, -M or -2M,
//    all at WIDTH+2 bits (wraps modulo 2^(WIDTH+2)).
//
//    Ports:
//       bits   in  3         {Q[1], Q[0], q_m1}
//       m_ext  in  WIDTH+2   multiplicand, already sign-extended
//       term   out WIDTH+2   selected term
// ---------------------------------------------------------------------------
module mul_32_booth_seq_booth_pair_recode
   import mul_32_booth_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       bits,
   input  logic [WIDTH+1:0] m_ext,
   output logic [WIDTH+1:0] term
);

   localparam logic [WIDTH+1:0] ONE = {{(WIDTH+1){1'b0}}, 1'b1};

   logic [WIDTH+1:0] m_neg;

   // Two's-complement negation at the extended width, so -MIN does not overflow
   assign m_neg = ~m_ext + ONE;

   always_comb begin
      term = '0;
      case (booth_select(bits))
         SEL_POS1: term = m_ext;
         SEL_POS2: term = m_ext << 1;
         SEL_NEG1: term = m_neg;
         SEL_NEG2: term = m_neg << 1;
         default:  term = '0;
      endcase
   end

endmodule

// File: rtl/mul_32_booth_seq.sv
// ---------------------------------------------------------------------------
// mul_32_booth_seq
//    Sequential signed multiplier, radix-4 Booth, 2 multiplier bits per
//    clock: WIDTH/2 iterations per product. Start/busy/done handshake; the
//    2*WIDTH-bit product is presented on hi/lo and held until the next one
//    completes.
//
//    Ports:
//       clk           in   1       rising-edge clock
//       clr           in   1       asynchronous active-low reset
//       start         in   1       request, sampled when not busy
//       multiplicand  in   WIDTH   signed M, captured on accepted start
//       multiplier    in   WIDTH   signed Q, captured on accepted start
//       busy          out  1       high while iterating
//       done          out  1       one-cycle pulse, hi/lo updated
//       hi            out  WIDTH   product upper half
//       lo            out  WIDTH   product lower half
// ---------------------------------------------------------------------------
module mul_32_booth_seq
   import mul_32_booth_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int N  = WIDTH / 2;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST     = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_e           state_q, state_d;
   logic [WIDTH+1:0] m_q, m_d;
   logic [WIDTH+1:0] acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             q_m1_q, q_m1_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH+1:0] term;
   logic [WIDTH+1:0] sum;
   logic [WIDTH+1:0] acc_shift;
   logic [WIDTH-1:0] q_shift;
   logic             q_m1_shift;

   mul_32_booth_seq_booth_pair_recode #(
      .WIDTH (WIDTH)
   ) u_recode (
      .bits  ({q_q[1:0], q_m1_q}),
      .m_ext (m_q),
      .term  (term)
   );

   // One iteration: add the Booth term, then arithmetic shift {sum,Q,q_m1}
   // right by two. The two low bits of sum move into the top of Q.
   always_comb begin
      sum        = acc_q + term;
      acc_shift  = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
      q_shift    = {sum[1:0], q_q[WIDTH-1:2]};
      q_m1_shift = q_q[1];
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      q_m1_d  = q_m1_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // DONE accepts a new start too, giving back-to-back operation
            if (start) begin
               state_d = ST_RUN;
               m_d     = {{2{multiplicand[WIDTH-1]}}, multiplicand};
               acc_d   = '0;
               q_d     = multiplier;
               q_m1_d  = 1'b0;
               count_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d   = acc_shift;
            q_d     = q_shift;
            q_m1_d  = q_m1_shift;
            count_d = count_q + CNT_ONE;
            if (count_q == LAST) begin
               state_d = ST_DONE;
               // Capture the post-shift values of the final iteration
               hi_d    = acc_shift[WIDTH-1:0];
               lo_d    = q_shift;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= ST_IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         q_m1_q  <= 1'b0;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         q_m1_q  <= q_m1_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
